// File: rtl/ttl_74597_pkg.sv
// Shared types for the 74597 PISO register: shift-register operation decode and default width.
package ttl_74597_pkg;

  localparam int TTL_74597_WIDTH = 8;

  typedef enum logic [1:0] {
    SR_HOLD  = 2'd0,
    SR_SHIFT = 2'd1,
    SR_LOAD  = 2'd2
  } sr_op_e;

  // Parallel load outranks shifting when both are requested on the same edge.
  function automatic sr_op_e sr_op(input logic load_bar, input logic shift_en);
    if (!load_bar) begin
      return SR_LOAD;
    end else if (shift_en) begin
      return SR_SHIFT;
    end
    return SR_HOLD;
  endfunction

endpackage

// File: rtl/ttl_74597_storage.sv
// Input storage register: WIDTH-bit enable register with synchronous clear.
// Latency: D visible on q one edge after en. Backpressure: none, en is a plain capture strobe.
module ttl_74597_storage
  import ttl_74597_pkg::*;
#(
  parameter int WIDTH = TTL_74597_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ttl_74597.sv
// 74597 parallel-in serial-out shift register with input storage; MSB-first on Q_H, cascade via Serial_In.
// Latency: D to Q_H is 2 edges (store, load); one bit per Shift_En edge. Backpressure: none.
// Define TTL_74597_COMPLEMENT_OUT_EN to add the Q_H_bar output.
module ttl_74597
  import ttl_74597_pkg::*;
#(
  parameter int WIDTH      = TTL_74597_WIDTH,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic             Clk,
  input  logic             Clear,
  input  logic             Store_En,
  input  logic             Load_bar,
  input  logic             Shift_En,
  input  logic             Serial_In,
  input  logic [WIDTH-1:0] D,
  output logic             Q_H
`ifdef TTL_74597_COMPLEMENT_OUT_EN
  ,
  output logic             Q_H_bar
`endif
);

  logic [WIDTH-1:0] store_q;
  logic [WIDTH-1:0] shift_q;
  sr_op_e           op;

  ttl_74597_storage #(
    .WIDTH(WIDTH)
  ) u_storage (
    .clk  (Clk),
    .clear(Clear),
    .en   (Store_En),
    .d    (D),
    .q    (store_q)
  );

  always_comb begin
    op = sr_op(Load_bar, Shift_En);
  end

  // Load takes the storage value from before this edge, so a same-edge store is not seen.
  always_ff @(posedge Clk) begin
    if (Clear) begin
      shift_q <= '0;
    end else begin
      case (op)
        SR_LOAD:  shift_q <= store_q;
        SR_SHIFT: shift_q <= {shift_q[WIDTH-2:0], Serial_In};
        default:  shift_q <= shift_q;
      endcase
    end
  end

  wire q_h_out;
  wire q_h_bar_out;

  // Board-level timing only applies when a nonzero delay is requested.
  generate
    if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : g_nodly
      assign q_h_out     = shift_q[WIDTH-1];
      assign q_h_bar_out = ~shift_q[WIDTH-1];
    end else begin : g_dly
      assign #(DELAY_RISE, DELAY_FALL) q_h_out     = shift_q[WIDTH-1];
      assign #(DELAY_RISE, DELAY_FALL) q_h_bar_out = ~shift_q[WIDTH-1];
    end
  endgenerate

  assign Q_H = q_h_out;

`ifdef TTL_74597_COMPLEMENT_OUT_EN
  assign Q_H_bar = q_h_bar_out;
`else
  logic unused_q_h_bar;
  assign unused_q_h_bar = q_h_bar_out;
`endif

endmodule

// File: tb/tb_ttl_74597.sv
// Scoreboard bench for ttl_74597: stimulus queues the expected Q_H per edge, a monitor pops and compares.
module tb_ttl_74597;

  logic       clk = 1'b0;
  logic       Clear = 1'b1;
  logic       Store_En = 1'b0;
  logic       Load_bar = 1'b1;
  logic       Shift_En = 1'b0;
  logic       Serial_In = 1'b0;
  logic [7:0] D = 8'h00;
  logic       Q_H;
`ifdef TTL_74597_COMPLEMENT_OUT_EN
  logic       Q_H_bar;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic  exp;
    string nm;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  ttl_74597 #(
    .WIDTH(8),
    .DELAY_RISE(0),
    .DELAY_FALL(0)
  ) dut (
    .Clk      (clk),
    .Clear    (Clear),
    .Store_En (Store_En),
    .Load_bar (Load_bar),
    .Shift_En (Shift_En),
    .Serial_In(Serial_In),
    .D        (D),
    .Q_H      (Q_H)
`ifdef TTL_74597_COMPLEMENT_OUT_EN
    ,
    .Q_H_bar  (Q_H_bar)
`endif
  );

  // Drive one edge's inputs on the falling edge and queue Q_H expected after the next rising edge.
  task automatic step(input logic clr, input logic se, input logic lb, input logic sh,
                      input logic si, input logic [7:0] d, input logic exp, input string nm);
    exp_t e;
    @(negedge clk);
    Clear     = clr;
    Store_En  = se;
    Load_bar  = lb;
    Shift_En  = sh;
    Serial_In = si;
    D         = d;
    e.exp = exp;
    e.nm  = nm;
    sbq.push_back(e);
  endtask

  // Monitor: one queued expectation per rising edge, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if (Q_H !== e.exp) begin
          errors++;
          $display("FAIL %s: Q_H=%b expected %b at %0t", e.nm, Q_H, e.exp, $time);
        end
`ifdef TTL_74597_COMPLEMENT_OUT_EN
        checks++;
        if (Q_H_bar !== ~e.exp) begin
          errors++;
          $display("FAIL %s_bar: Q_H_bar=%b expected %b at %0t", e.nm, Q_H_bar, ~e.exp, $time);
        end
`endif
      end
    end
  end

  initial begin
    logic [7:0] a5;
    logic [7:0] w3c;
    int wait_cyc;
    a5  = 8'hA5;
    w3c = 8'h3C;

    // Reset values.
    step(1, 0, 1, 0, 0, 8'h00, 1'b0, "reset0");
    step(1, 1, 0, 1, 1, 8'hFF, 1'b0, "reset1");
    step(0, 0, 1, 0, 0, 8'h00, 1'b0, "idle");

    // Store A5, load, shift out MSB-first with Serial_In=0.
    step(0, 1, 1, 0, 0, 8'hA5, 1'b0, "store_a5");
    step(0, 0, 0, 0, 0, 8'h00, a5[7], "load_a5");
    for (int k = 1; k < 8; k++) begin
      step(0, 0, 1, 1, 0, 8'h00, a5[7-k], $sformatf("shift_a5_%0d", k));
    end
    step(0, 0, 1, 1, 0, 8'h00, 1'b0, "shift_a5_8");

    // Same-edge store and load: shift register receives old storage (3C), not FF.
    step(0, 1, 1, 0, 0, 8'h3C, 1'b0, "store_3c");
    step(0, 1, 0, 0, 0, 8'hFF, w3c[7], "store_load_same");
    for (int k = 1; k < 8; k++) begin
      step(0, 0, 1, 1, 0, 8'h00, w3c[7-k], $sformatf("shift_3c_%0d", k));
    end
    step(0, 0, 0, 0, 0, 8'h00, 1'b1, "reload_ff");

    // Load beats shift; shift register then holds while idle.
    step(0, 1, 1, 0, 0, 8'h40, 1'b1, "store_40");
    step(0, 0, 0, 1, 1, 8'h00, 1'b0, "load_over_shift");
    step(0, 0, 1, 1, 0, 8'h00, 1'b1, "shift_40");
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, 0, 1, 8'h5A, 1'b1, $sformatf("hold_%0d", k));
    end
    step(0, 0, 1, 1, 0, 8'h00, 1'b0, "shift_after_hold");

    // Cascade: load 00, shift in eight ones, then shift them back out.
    step(0, 1, 1, 0, 0, 8'h00, 1'b0, "store_00");
    step(0, 0, 0, 0, 0, 8'h00, 1'b0, "load_00");
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 1, 1, 1, 8'h00, (k == 8), $sformatf("cascade_in_%0d", k));
    end
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 1, 1, 0, 8'h00, (k < 8), $sformatf("cascade_out_%0d", k));
    end

    // Clear mid-transmission abandons the word and empties storage.
    step(0, 1, 1, 0, 0, 8'hFF, 1'b0, "store_ff");
    step(0, 0, 0, 0, 0, 8'h00, 1'b1, "load_ff");
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 1, 1, 0, 8'h00, 1'b1, $sformatf("shift_ff_%0d", k));
    end
    step(1, 1, 0, 1, 1, 8'hAA, 1'b0, "clear_mid");
    step(0, 0, 0, 0, 0, 8'h00, 1'b0, "load_after_clear");
    step(0, 0, 1, 1, 1, 8'h00, 1'b0, "shift_after_clear");

    @(negedge clk);
    Shift_En = 1'b0;
    wait_cyc = 0;
    while (sbq.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
